// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared state encoding and defaults for the button debouncer
package debounce_pkg;

  localparam logic [1:0] ST_STABLE_LOW  = 2'd0;
  localparam logic [1:0] ST_CHECK_HIGH  = 2'd1;
  localparam logic [1:0] ST_STABLE_HIGH = 2'd2;
  localparam logic [1:0] ST_CHECK_LOW   = 2'd3;

  localparam int DEFAULT_STABLE_CYCLES = 1000000;

  typedef enum logic [1:0] {
    STABLE_LOW  = ST_STABLE_LOW,
    CHECK_HIGH  = ST_CHECK_HIGH,
    STABLE_HIGH = ST_STABLE_HIGH,
    CHECK_LOW   = ST_CHECK_LOW
  } db_state_t;

endpackage

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - single-bit synchroniser, stability FSM and edge strobes
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_in,
  output logic db_out,
  output logic rise_pulse,
  output logic fall_pulse
);

  localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             s1, s2;
  db_state_t        state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             db_n, rise_n, fall_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1         <= 1'b0;
      s2         <= 1'b0;
      state      <= STABLE_LOW;
      cnt        <= '0;
      db_out     <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      s1         <= raw_in;
      s2         <= s1;
      state      <= state_n;
      cnt        <= cnt_n;
      db_out     <= db_n;
      rise_pulse <= rise_n;
      fall_pulse <= fall_n;
    end
  end

  // Outputs are registered from the next state so they change on the same edge as the FSM.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    rise_n  = 1'b0;
    fall_n  = 1'b0;
    case (state)
      STABLE_LOW: begin
        if (s2) begin
          state_n = CHECK_HIGH;
          cnt_n   = '0;
        end
      end
      CHECK_HIGH: begin
        if (!s2) begin
          state_n = STABLE_LOW;
          cnt_n   = '0;
        end else if (cnt == CNT_LAST) begin
          state_n = STABLE_HIGH;
          rise_n  = 1'b1;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      STABLE_HIGH: begin
        if (!s2) begin
          state_n = CHECK_LOW;
          cnt_n   = '0;
        end
      end
      CHECK_LOW: begin
        if (s2) begin
          state_n = STABLE_HIGH;
          cnt_n   = '0;
        end else if (cnt == CNT_LAST) begin
          state_n = STABLE_LOW;
          fall_n  = 1'b1;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_n = STABLE_LOW;
        cnt_n   = '0;
      end
    endcase
    db_n = (state_n == STABLE_HIGH) || (state_n == CHECK_LOW);
  end

endmodule

// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - NUM_CH independent debounce channels for board buttons and switches
module button_debouncer
  import debounce_pkg::*;
#(
  parameter int NUM_CH        = 2,
  parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] raw_in,
  output logic [NUM_CH-1:0] db_out,
  output logic [NUM_CH-1:0] rise_pulse,
  output logic [NUM_CH-1:0] fall_pulse
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    debounce_channel #(
      .STABLE_CYCLES(STABLE_CYCLES)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .raw_in    (raw_in[i]),
      .db_out    (db_out[i]),
      .rise_pulse(rise_pulse[i]),
      .fall_pulse(fall_pulse[i])
    );
  end

endmodule

// File: tb/tb_button_debouncer.sv
// tb/tb_button_debouncer.sv - directed self-checking bench for button_debouncer
module tb_button_debouncer;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] raw_in;
  logic [1:0] db_out, rise_pulse, fall_pulse;

  int checks = 0;
  int passed = 0;

  button_debouncer #(
    .NUM_CH       (2),
    .STABLE_CYCLES(4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .raw_in    (raw_in),
    .db_out    (db_out),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  // Advance n edges; after each, sample 1 time unit past the edge and compare all outputs.
  task automatic expect_for(input int n, input logic [1:0] e_db, input logic [1:0] e_rise,
                            input logic [1:0] e_fall, input string tag);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      chk({tag, " db_out"}, db_out, e_db);
      chk({tag, " rise_pulse"}, rise_pulse, e_rise);
      chk({tag, " fall_pulse"}, fall_pulse, e_fall);
    end
  endtask

  initial begin
    reset  = 1'b1;
    raw_in = 2'b11;

    // Reset held with both pins high: nothing may come out.
    expect_for(3, 2'b00, 2'b00, 2'b00, "reset_hold");
    reset = 1'b0;
    expect_for(6, 2'b00, 2'b00, 2'b00, "post_reset_wait");
    expect_for(1, 2'b11, 2'b11, 2'b00, "post_reset_rise");
    expect_for(1, 2'b11, 2'b00, 2'b00, "post_reset_hold");

    // Release both channels one after the other.
    raw_in = 2'b10;
    expect_for(6, 2'b11, 2'b00, 2'b00, "rel0_wait");
    expect_for(1, 2'b10, 2'b00, 2'b01, "rel0_fall");
    expect_for(1, 2'b10, 2'b00, 2'b00, "rel0_hold");
    raw_in = 2'b00;
    expect_for(6, 2'b10, 2'b00, 2'b00, "rel1_wait");
    expect_for(1, 2'b00, 2'b00, 2'b10, "rel1_fall");
    expect_for(1, 2'b00, 2'b00, 2'b00, "rel1_hold");

    // Clean press and release of channel 0.
    raw_in = 2'b01;
    expect_for(6, 2'b00, 2'b00, 2'b00, "press_wait");
    expect_for(1, 2'b01, 2'b01, 2'b00, "press_rise");
    expect_for(1, 2'b01, 2'b00, 2'b00, "press_hold");
    raw_in = 2'b00;
    expect_for(6, 2'b01, 2'b00, 2'b00, "release_wait");
    expect_for(1, 2'b00, 2'b00, 2'b01, "release_fall");
    expect_for(1, 2'b00, 2'b00, 2'b00, "release_hold");

    // Bounce 1,0,1,0 at two cycles each, then settle high.
    raw_in = 2'b01;
    expect_for(2, 2'b00, 2'b00, 2'b00, "bounce_a");
    raw_in = 2'b00;
    expect_for(2, 2'b00, 2'b00, 2'b00, "bounce_b");
    raw_in = 2'b01;
    expect_for(2, 2'b00, 2'b00, 2'b00, "bounce_c");
    raw_in = 2'b00;
    expect_for(2, 2'b00, 2'b00, 2'b00, "bounce_d");
    raw_in = 2'b01;
    expect_for(6, 2'b00, 2'b00, 2'b00, "bounce_settle");
    expect_for(1, 2'b01, 2'b01, 2'b00, "bounce_rise");
    expect_for(1, 2'b01, 2'b00, 2'b00, "bounce_hold");
    raw_in = 2'b00;
    expect_for(6, 2'b01, 2'b00, 2'b00, "bounce_rel_wait");
    expect_for(1, 2'b00, 2'b00, 2'b01, "bounce_rel_fall");
    expect_for(1, 2'b00, 2'b00, 2'b00, "bounce_rel_hold");

    // Four-cycle pulse on channel 1 is one cycle short of acceptance.
    raw_in = 2'b10;
    expect_for(4, 2'b00, 2'b00, 2'b00, "glitch4_high");
    raw_in = 2'b00;
    expect_for(8, 2'b00, 2'b00, 2'b00, "glitch4_after");

    // Five-cycle pulse is accepted, then its trailing low is accepted too.
    raw_in = 2'b10;
    expect_for(5, 2'b00, 2'b00, 2'b00, "pulse5_high");
    raw_in = 2'b00;
    expect_for(1, 2'b00, 2'b00, 2'b00, "pulse5_edge5");
    expect_for(1, 2'b10, 2'b10, 2'b00, "pulse5_rise");
    expect_for(4, 2'b10, 2'b00, 2'b00, "pulse5_checklow");
    expect_for(1, 2'b00, 2'b00, 2'b10, "pulse5_fall");
    expect_for(1, 2'b00, 2'b00, 2'b00, "pulse5_hold");

    // Reset in the middle of a count aborts it; the count restarts after release.
    raw_in = 2'b01;
    expect_for(4, 2'b00, 2'b00, 2'b00, "midreset_count");
    reset = 1'b1;
    expect_for(1, 2'b00, 2'b00, 2'b00, "midreset_edge");
    reset = 1'b0;
    expect_for(6, 2'b00, 2'b00, 2'b00, "midreset_wait");
    expect_for(1, 2'b01, 2'b01, 2'b00, "midreset_rise");
    expect_for(1, 2'b01, 2'b00, 2'b00, "midreset_hold");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
